// File: rtl/tcdm_bank_responder.sv
// -----------------------------------------------------------------------------
// tcdm_bank_responder
//
// Bank-side responder for the TCDM interconnect. Terminates one bank port,
// holds a word-addressed storage array with byte-enable writes, and returns
// load data exactly MemLatency cycles after the grant edge.
//
// Optional build macro: TCDM_BANK_RAND_STALL_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) denies roughly
//   one request in four to exercise arbitration and retry in the interconnect.
//   When undefined, every request is granted.
//
// Ports:
//   clk_i     in   1             clock, rising edge
//   rst_i     in   1             asynchronous active-high reset
//   req_i     in   1             bank request
//   gnt_o     out  1             grant (combinational)
//   add_i     in   AddrMemWidth  word address
//   wen_i     in   1             1 = store, 0 = load
//   wdata_i   in   DataWidth     store data
//   be_i      in   BeWidth       store byte enables
//   rdata_o   out  DataWidth     load data, registered, holds between loads
//   rvalid_o  out  1             pulses MemLatency cycles after any grant
//   rd_cnt_o  out  32            granted loads, saturating
//   wr_cnt_o  out  32            granted stores, saturating
// -----------------------------------------------------------------------------
module tcdm_bank_responder #(
  parameter int          AddrMemWidth = 12,
  parameter int          DataWidth    = 32,
  parameter int          BeWidth      = DataWidth / 8,
  parameter int          MemLatency   = 1,
  parameter logic [15:0] StallSeed    = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    rvalid_o,
  output logic [31:0]             rd_cnt_o,
  output logic [31:0]             wr_cnt_o
);

  localparam int Depth = 2 ** AddrMemWidth;

  // Parameter sanity checks, evaluated at elaboration.
  if (MemLatency < 1 || MemLatency > 8) begin : gBadLatency
    $fatal(1, "tcdm_bank_responder: MemLatency must be within 1..8");
  end
  if ((DataWidth % 8) != 0) begin : gBadWidth
    $fatal(1, "tcdm_bank_responder: DataWidth must be a multiple of 8");
  end
  if (StallSeed == 16'h0000) begin : gBadSeed
    $fatal(1, "tcdm_bank_responder: StallSeed must be nonzero");
  end

  logic w_stallOk;

`ifdef TCDM_BANK_RAND_STALL_EN
  logic [15:0] r_lfsr;

  // Free-running stall generator; a request is denied whenever the two
  // low LFSR bits are both zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= StallSeed;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stallOk = (r_lfsr[1:0] != 2'b00);
`else
  assign w_stallOk = 1'b1;
`endif

  logic w_load;
  logic w_store;

  // The grant is forced low during reset so nothing is accepted while the
  // pipeline is being cleared.
  assign gnt_o   = req_i & ~rst_i & w_stallOk;
  assign w_load  = gnt_o & ~wen_i;
  assign w_store = gnt_o & wen_i;

  logic [DataWidth-1:0] r_mem [Depth];
  logic [DataWidth-1:0] w_memRd;

  // Storage array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BeWidth; b++) begin
      if (w_store && be_i[b]) begin
        r_mem[add_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Loads sample the word as it stands before the current edge.
  assign w_memRd = r_mem[add_i];

  logic [MemLatency-1:0] r_stgValid;

  // Valid bits for every stage; reset drops anything still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stgValid <= '0;
    end else begin
      r_stgValid[0] <= gnt_o;
      for (int i = 1; i < MemLatency; i++) begin
        r_stgValid[i] <= r_stgValid[i-1];
      end
    end
  end

  // The final stage's data register is rdata_o itself, so these signals are
  // what is about to enter that final stage at the next edge.
  logic                 w_lastInValid;
  logic                 w_lastInLoad;
  logic [DataWidth-1:0] w_lastInData;

  if (MemLatency > 1) begin : gDataPipe
    logic [DataWidth-1:0] r_stgData [MemLatency-1];
    logic [MemLatency-2:0] r_stgLoad;

    // Load flag and data for the intermediate stages; validity is tracked
    // separately, so these need no reset.
    always_ff @(posedge clk_i) begin
      r_stgData[0] <= w_memRd;
      r_stgLoad[0] <= w_load;
      for (int i = 1; i < MemLatency - 1; i++) begin
        r_stgData[i] <= r_stgData[i-1];
        r_stgLoad[i] <= r_stgLoad[i-1];
      end
    end

    assign w_lastInValid = r_stgValid[MemLatency-2];
    assign w_lastInLoad  = r_stgLoad[MemLatency-2];
    assign w_lastInData  = r_stgData[MemLatency-2];
  end else begin : gNoPipe
    assign w_lastInValid = gnt_o;
    assign w_lastInLoad  = w_load;
    assign w_lastInData  = w_memRd;
  end

  logic [DataWidth-1:0] r_rdata;

  // Read data only changes when a load completes; store completions and idle
  // cycles leave the last load value in place.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (w_lastInValid && w_lastInLoad) begin
      r_rdata <= w_lastInData;
    end
  end

  logic [31:0] r_rdCnt;
  logic [31:0] r_wrCnt;
  logic [31:0] w_rdCntNext;
  logic [31:0] w_wrCntNext;

  assign w_rdCntNext = (w_load && (r_rdCnt != 32'hFFFF_FFFF)) ? r_rdCnt + 32'd1 : r_rdCnt;
  assign w_wrCntNext = (w_store && (r_wrCnt != 32'hFFFF_FFFF)) ? r_wrCnt + 32'd1 : r_wrCnt;

  // Saturating access counters, rewritten every cycle from their next value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdCnt <= '0;
      r_wrCnt <= '0;
    end else begin
      r_rdCnt <= w_rdCntNext;
      r_wrCnt <= w_wrCntNext;
    end
  end

  assign rdata_o  = r_rdata;
  assign rvalid_o = r_stgValid[MemLatency-1];
  assign rd_cnt_o = r_rdCnt;
  assign wr_cnt_o = r_wrCnt;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// -----------------------------------------------------------------------------
// tb_tcdm_bank_responder
//
// Drives three responders (MemLatency 1, 3 and 4) from one shared stimulus
// stream. A reference model records every granted access as a timestamped
// event and derives the expected response of each instance from its latency.
// Honours TCDM_BANK_RAND_STALL_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_tcdm_bank_responder;

  localparam int          AW         = 12;
  localparam int          DW         = 32;
  localparam int          BW         = 4;
  localparam logic [15:0] Seed       = 16'hACE1;
  localparam int          NumDut     = 3;
  localparam int          MaxEv      = 4096;
  localparam int          ModelWords = 32;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          req   = 1'b0;
  logic          wen   = 1'b0;
  logic [AW-1:0] add   = '0;
  logic [DW-1:0] wdata = '0;
  logic [BW-1:0] be    = '0;

  logic          gntA    [NumDut];
  logic [DW-1:0] rdataA  [NumDut];
  logic          rvalidA [NumDut];
  logic [31:0]   rdCntA  [NumDut];
  logic [31:0]   wrCntA  [NumDut];

  int latA [NumDut] = '{1, 3, 4};

  always #5 clk = ~clk;

  tcdm_bank_responder #(.AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW),
                        .MemLatency(1), .StallSeed(Seed)) u_dutL1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gntA[0]), .add_i(add),
    .wen_i(wen), .wdata_i(wdata), .be_i(be), .rdata_o(rdataA[0]),
    .rvalid_o(rvalidA[0]), .rd_cnt_o(rdCntA[0]), .wr_cnt_o(wrCntA[0]));

  tcdm_bank_responder #(.AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW),
                        .MemLatency(3), .StallSeed(Seed)) u_dutL3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gntA[1]), .add_i(add),
    .wen_i(wen), .wdata_i(wdata), .be_i(be), .rdata_o(rdataA[1]),
    .rvalid_o(rvalidA[1]), .rd_cnt_o(rdCntA[1]), .wr_cnt_o(wrCntA[1]));

  tcdm_bank_responder #(.AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW),
                        .MemLatency(4), .StallSeed(Seed)) u_dutL4 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gntA[2]), .add_i(add),
    .wen_i(wen), .wdata_i(wdata), .be_i(be), .rdata_o(rdataA[2]),
    .rvalid_o(rvalidA[2]), .rd_cnt_o(rdCntA[2]), .wr_cnt_o(wrCntA[2]));

  // Reference model state: one event slot per clock edge, a shadow of the
  // words the bench has written, and the expected counter values.
  int            nChecks    = 0;
  int            nFails     = 0;
  int            cyc        = 0;
  int            flushIdx   = 0;
  int            grantCount = 0;
  int            lowCount   = 0;
  bit            evValid [MaxEv];
  bit            evLoad  [MaxEv];
  logic [DW-1:0] evData  [MaxEv];
  logic [DW-1:0] mdl     [ModelWords];
  logic [31:0]   expRd   = '0;
  logic [31:0]   expWr   = '0;

`ifdef TCDM_BANK_RAND_STALL_EN
  logic [15:0] mdlLfsr = Seed;

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
`endif

  function automatic bit stallOk();
`ifdef TCDM_BANK_RAND_STALL_EN
    return (mdlLfsr[1:0] != 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  // The response visible now at latency lat belongs to the edge lat edges ago.
  function automatic bit expRvalid(input int lat);
    int j;
    j = cyc - lat;
    if (j < flushIdx || j < 0) return 1'b0;
    return evValid[j];
  endfunction

  // rdata holds the most recent completed load since the last reset.
  function automatic logic [31:0] expRdata(input int lat);
    for (int i = cyc - lat; i >= flushIdx && i >= 0; i--) begin
      if (evValid[i] && evLoad[i]) return evData[i];
    end
    return '0;
  endfunction

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < NumDut; k++) begin
      checkVal($sformatf("rvalid_L%0d", latA[k]), {31'd0, rvalidA[k]}, {31'd0, expRvalid(latA[k])});
      checkVal($sformatf("rdata_L%0d", latA[k]), rdataA[k], expRdata(latA[k]));
      checkVal($sformatf("rdcnt_L%0d", latA[k]), rdCntA[k], expRd);
      checkVal($sformatf("wrcnt_L%0d", latA[k]), wrCntA[k], expWr);
    end
  endtask

  // One clock cycle: drive inputs just after an edge, check the grant, take
  // the edge, advance the model, then check the registered outputs.
  task automatic applyStimulus(input bit r, input bit w, input int a,
                               input logic [31:0] d, input logic [3:0] b);
    bit g;
    req   = r;
    wen   = w;
    add   = AW'(a);
    wdata = d;
    be    = b;
    g = r && stallOk();
    #1;
    for (int k = 0; k < NumDut; k++) begin
      checkVal($sformatf("gnt_L%0d", latA[k]), {31'd0, gntA[k]}, {31'd0, g});
    end
    if (r && !gntA[0]) lowCount++;
    @(posedge clk);
    if (cyc >= MaxEv) begin
      $display("[TB] FAIL event_budget: observed %0d expected below %0d", cyc, MaxEv);
      $fatal(1, "[TB] event budget exhausted");
    end
    evValid[cyc] = g;
    evLoad[cyc]  = g && !w;
    evData[cyc]  = mdl[a];
    if (g) begin
      grantCount++;
      if (w) begin
        for (int l = 0; l < BW; l++) begin
          if (b[l]) mdl[a][8*l +: 8] = d[8*l +: 8];
        end
        expWr = satInc(expWr);
      end else begin
        expRd = satInc(expRd);
      end
    end
    cyc++;
`ifdef TCDM_BANK_RAND_STALL_EN
    mdlLfsr = lfsrStep(mdlLfsr);
`endif
    #1;
    checkOutput();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear at once, in-flight
  // responses are discarded, and nothing is granted while it is held.
  task automatic doReset(input int n);
    rst = 1'b1;
    #1;
    flushIdx   = cyc;
    expRd      = '0;
    expWr      = '0;
    grantCount = 0;
    lowCount   = 0;
`ifdef TCDM_BANK_RAND_STALL_EN
    mdlLfsr = Seed;
`endif
    for (int k = 0; k < NumDut; k++) begin
      checkVal($sformatf("gnt_in_reset_L%0d", latA[k]), {31'd0, gntA[k]}, 32'd0);
    end
    checkOutput();
    repeat (n) begin
      @(posedge clk);
      evValid[cyc] = 1'b0;
      evLoad[cyc]  = 1'b0;
      cyc++;
    end
    #1;
    rst = 1'b0;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          rr;
    bit          ww;
    int          aa;
    logic [31:0] dd;
    logic [3:0]  bb;

    #2;
    doReset(2);

    // Fill the modelled region so every later load has a known answer.
    for (int a = 0; a < ModelWords; a++) begin
      applyStimulus(1'b1, 1'b1, a, $urandom, 4'hF);
    end

    // Store then load back-to-back.
    applyStimulus(1'b1, 1'b1, 'h010, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1'b1, 1'b0, 'h010, 32'h0, 4'h0);
`ifndef TCDM_BANK_RAND_STALL_EN
    checkVal("store_then_load_L1", rdataA[0], 32'hDEAD_BEEF);
`endif

    // Byte-enable merge and an all-disabled store.
    applyStimulus(1'b1, 1'b1, 'h005, 32'h1122_3344, 4'hF);
    applyStimulus(1'b1, 1'b1, 'h005, 32'hAABB_CCDD, 4'b0101);
    applyStimulus(1'b1, 1'b0, 'h005, 32'h0, 4'h0);
`ifndef TCDM_BANK_RAND_STALL_EN
    checkVal("be_merge_L1", rdataA[0], 32'h11BB_33DD);
`endif
    applyStimulus(1'b1, 1'b1, 'h005, 32'hFFFF_FFFF, 4'h0);
    applyStimulus(1'b1, 1'b0, 'h005, 32'h0, 4'h0);
`ifndef TCDM_BANK_RAND_STALL_EN
    checkVal("be_zero_keeps_word_L1", rdataA[0], 32'h11BB_33DD);
    checkVal("be_zero_counted", wrCntA[0], 32'd36);
`endif

    // Reset with three loads in flight in the deeper instances.
    applyStimulus(1'b1, 1'b0, 1, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 2, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 3, 32'h0, 4'h0);
    doReset(1);
    repeat (6) applyStimulus(1'b0, 1'b0, 0, 32'h0, 4'h0);

    // Array contents survive reset.
    applyStimulus(1'b1, 1'b0, 'h010, 32'h0, 4'h0);
`ifndef TCDM_BANK_RAND_STALL_EN
    checkVal("retained_after_reset_L1", rdataA[0], 32'hDEAD_BEEF);
`endif

    // Eight back-to-back loads, then idle so the latency-4 pipe drains.
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b1, 1'b0, a, 32'h0, 4'h0);
    end
    repeat (6) applyStimulus(1'b0, 1'b0, 0, 32'h0, 4'h0);

    // Randomized traffic over the modelled region.
    for (int i = 0; i < 300; i++) begin
      rr = ($urandom_range(0, 3) != 0);
      ww = 1'($urandom_range(0, 1));
      aa = int'($urandom_range(0, ModelWords - 1));
      dd = $urandom;
      bb = 4'($urandom_range(0, 15));
      applyStimulus(rr, ww, aa, dd, bb);
    end
    repeat (5) applyStimulus(1'b0, 1'b0, 0, 32'h0, 4'h0);

    // Load counter saturation from just below the top.
    force u_dutL1.r_rdCnt = 32'hFFFF_FFFE;
    force u_dutL3.r_rdCnt = 32'hFFFF_FFFE;
    force u_dutL4.r_rdCnt = 32'hFFFF_FFFE;
    expRd = 32'hFFFF_FFFE;
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 4'h0);
    release u_dutL1.r_rdCnt;
    release u_dutL3.r_rdCnt;
    release u_dutL4.r_rdCnt;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, i, 32'h0, 4'h0);
    end
`ifndef TCDM_BANK_RAND_STALL_EN
    checkVal("rd_cnt_saturated", rdCntA[0], 32'hFFFF_FFFF);
`endif

`ifdef TCDM_BANK_RAND_STALL_EN
    // Continuous requests: denial rate and grant accounting.
    doReset(1);
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, ModelWords - 1)),
                    $urandom, 4'hF);
    end
    checkVal("stall_low_in_range", {31'd0, (lowCount >= 200 && lowCount <= 300)}, 32'd1);
    checkVal("grants_equal_counts", rdCntA[0] + wrCntA[0], 32'(grantCount));
`endif

    $display("[TB] granted accesses since last reset: %0d", grantCount);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
